// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path:
// op codes, command entry and sequencer states.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SHL   = 4'b0010;
  localparam logic [3:0] OP_SHR   = 4'b0011;
  localparam logic [3:0] OP_CMP   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_XNOR  = 4'b1010;
  localparam logic [3:0] OP_NOT   = 4'b1011;
  localparam logic [3:0] OP_NEG   = 4'b1100;
  localparam logic [3:0] OP_STORE = 4'b1101;
  localparam logic [3:0] OP_SWAP  = 4'b1110;
  localparam logic [3:0] OP_LOAD  = 4'b1111;

  localparam int CMD_W = 12;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_RESULT = 2'd2
  } seq_state_e;

  // Write ops change ALU state and produce no result.
  function automatic logic is_write_op(input logic [3:0] op);
    return (op == OP_STORE) ||
           (op == OP_SWAP)  ||
           (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO (DEPTH x cmd_t).
// Push when full and pop when empty are ignored.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  cmd_t          wr_data,
  input  logic          pop,
  output cmd_t          rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued commands to the ALU one at a time,
// holds them to settle and returns compute results.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         SETTLE   = 2,
  parameter logic [3:0] IDLE_SEL = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [3:0] alu_sel,
  output logic [7:0] alu_data,
  input  logic [7:0] alu_y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [3:0] res_op,
  output logic       busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  cmd_t          push_ent;
  cmd_t          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;

  seq_state_e    state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    dat_q, dat_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          rv_q, rv_d;
  logic [7:0]    rdat_q, rdat_d;
  logic [3:0]    rop_q, rop_d;

  assign push_ent.op   = cmd_op;
  assign push_ent.data = cmd_data;

  assign fifo_pop = (state_q == ST_IDLE) & ~fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid),
    .wr_data (push_ent),
    .pop     (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign cmd_ready = ~fifo_full;
  assign busy      = (state_q != ST_IDLE) |
                     (fifo_count != '0);
  assign alu_sel   = sel_q;
  assign alu_data  = dat_q;
  assign res_valid = rv_q;
  assign res_data  = rdat_q;
  assign res_op    = rop_q;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= IDLE_SEL;
      dat_q   <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rdat_q  <= '0;
      rop_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rdat_q  <= rdat_d;
      rop_q   <= rop_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = is_write_op(sel_q) ? ST_IDLE
                                       : ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next ALU drive, settle count and result.
  always_comb begin
    sel_d  = sel_q;
    dat_d  = dat_q;
    cnt_d  = cnt_q;
    rv_d   = rv_q;
    rdat_d = rdat_q;
    rop_d  = rop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          sel_d = head.op;
          dat_d = head.data;
          cnt_d = SW'(SETTLE - 1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SW'(1);
        end else begin
          sel_d = IDLE_SEL;
          dat_d = '0;
          if (!is_write_op(sel_q)) begin
            rdat_d = alu_y;
            rop_d  = sel_q;
            rv_d   = 1'b1;
          end
        end
      end
      ST_RESULT: begin
        if (res_ready) rv_d = 1'b0;
      end
      default: begin
        sel_d = IDLE_SEL;
        dat_d = '0;
        rv_d  = 1'b0;
      end
    endcase
  end

endmodule
